// File: rtl/fpsu_alt_pkg.sv
// Shared types and helpers for the FPSU ALT-slot arbiter.
//   alt_entry_t : one queued operand (high half, low half, tag)
//   rr_pick     : round-robin scan returning the first and second set bits
//                 of a non-empty vector, starting at a pointer.
package fpsu_alt_pkg;
  localparam int ALT_W     = 68;
  localparam int ALT_TAGW  = 9;
  localparam int ALT_SLOTS = 2;
  localparam int RR_MAX    = 8;  // widest requester set the scan supports

  typedef struct packed {
    logic [ALT_W-1:0]    dataH;
    logic [ALT_W-1:0]    dataL;
    logic [ALT_TAGW-1:0] tag;
  } alt_entry_t;

  typedef struct packed {
    logic       v0;
    logic [2:0] i0;
    logic       v1;
    logic [2:0] i1;
  } rr_pick_t;

  // Walk ptr, ptr+1, ... (mod nreq). The two winners are always distinct
  // requesters because each index is visited once.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] ne,
                                       input logic [2:0] ptr,
                                       input int unsigned nreq);
    rr_pick_t    r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      if (k < nreq) begin
        idx = ({29'd0, ptr} + k) % nreq;
        if (ne[idx[2:0]]) begin
          if (!r.v0) begin
            r.v0 = 1'b1;
            r.i0 = idx[2:0];
          end else if (!r.v1) begin
            r.v1 = 1'b1;
            r.i1 = idx[2:0];
          end
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/fpsu_alt_fifo.sv
// Per-requester operand FIFO, DEPTH entries of alt_entry_t.
// Ports: clk, rst (async high), push/din, pop/dout (head, valid when !empty),
//        full, empty, count.
// Pointers carry one wrap bit so full and empty are distinguishable.
module fpsu_alt_fifo
  import fpsu_alt_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  alt_entry_t               din,
  input  logic                     pop,
  output alt_entry_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp, rp;
  alt_entry_t  mem [DEPTH];
  logic        do_push, do_pop;

  // Gating on the pre-edge state makes a full FIFO refuse a push even when
  // it pops in the same cycle, and an empty FIFO ignore a pop.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

  assign dout  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
endmodule

// File: rtl/fpsu_alt_arb.sv
// Round-robin arbiter feeding the two ALT slots of the dual-half FPSU.
// Ports: clk, rst (async high); req_vld/req_rdy/req_dataH/req_dataL/req_tag
//        per-requester push interface (requester i at [i*W +: W]);
//        stall from the FPSU; registered slot outputs ALT_INP, ALTDATAH0/1,
//        ALTDATAL0/1, alt_tag0/1, alt_src0/1; busy.
// W and TAGW must match the entry widths in fpsu_alt_pkg.
module fpsu_alt_arb
  import fpsu_alt_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int W     = ALT_W,
  parameter int TAGW  = ALT_TAGW,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_vld,
  output logic [NREQ-1:0]        req_rdy,
  input  logic [NREQ*W-1:0]      req_dataH,
  input  logic [NREQ*W-1:0]      req_dataL,
  input  logic [NREQ*TAGW-1:0]   req_tag,
  input  logic                   stall,
  output logic [ALT_SLOTS-1:0]   ALT_INP,
  output logic [W-1:0]           ALTDATAH0,
  output logic [W-1:0]           ALTDATAH1,
  output logic [W-1:0]           ALTDATAL0,
  output logic [W-1:0]           ALTDATAL1,
  output logic [TAGW-1:0]        alt_tag0,
  output logic [TAGW-1:0]        alt_tag1,
  output logic [2:0]             alt_src0,
  output logic [2:0]             alt_src1,
  output logic                   busy
);
  localparam int CW = $clog2(DEPTH) + 1;

  alt_entry_t                head [RR_MAX];
  logic [RR_MAX-1:0]         ne;
  logic [NREQ-1:0]           pop, full;
  logic [NREQ-1:0][CW-1:0]   cnt;
  rr_pick_t                  pk;
  logic [2:0]                rr_ptr, last, rr_nxt;

  // Unused scan positions are padded as permanently empty so the scan
  // helper can always work on the full RR_MAX-wide vector.
  for (genvar i = 0; i < RR_MAX; i++) begin : g_req
    if (i < NREQ) begin : g_fifo
      alt_entry_t din;
      logic       emp;
      assign din = '{dataH: req_dataH[i*W +: W],
                     dataL: req_dataL[i*W +: W],
                     tag:   req_tag[i*TAGW +: TAGW]};
      assign ne[i]  = ~emp;
      assign pop[i] = (pk.v0 && pk.i0 == 3'(i)) || (pk.v1 && pk.i1 == 3'(i));
      fpsu_alt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_vld[i] & ~full[i]),
        .din   (din),
        .pop   (pop[i]),
        .dout  (head[i]),
        .full  (full[i]),
        .empty (emp),
        .count (cnt[i])
      );
    end else begin : g_pad
      assign head[i] = '0;
      assign ne[i]   = 1'b0;
    end
  end

  assign req_rdy = ~full;

  // A stalled cycle grants nothing, which also freezes pops and rr_ptr.
  assign pk     = stall ? '0 : rr_pick(ne, rr_ptr, NREQ);
  assign last   = pk.v1 ? pk.i1 : pk.i0;
  assign rr_nxt = (32'(last) == NREQ - 1) ? 3'd0 : last + 3'd1;
  assign busy   = (|cnt) | (|ALT_INP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALT_INP   <= '0;
      ALTDATAH0 <= '0;
      ALTDATAH1 <= '0;
      ALTDATAL0 <= '0;
      ALTDATAL1 <= '0;
      alt_tag0  <= '0;
      alt_tag1  <= '0;
      alt_src0  <= '0;
      alt_src1  <= '0;
      rr_ptr    <= '0;
    end else if (!stall) begin
      ALT_INP <= {pk.v1, pk.v0};
      // Ungranted slots keep their payload; only the valid bit drops.
      if (pk.v0) begin
        ALTDATAH0 <= head[pk.i0].dataH;
        ALTDATAL0 <= head[pk.i0].dataL;
        alt_tag0  <= head[pk.i0].tag;
        alt_src0  <= pk.i0;
        rr_ptr    <= rr_nxt;
      end
      if (pk.v1) begin
        ALTDATAH1 <= head[pk.i1].dataH;
        ALTDATAL1 <= head[pk.i1].dataL;
        alt_tag1  <= head[pk.i1].tag;
        alt_src1  <= pk.i1;
      end
    end
  end
endmodule

// File: tb/tb_fpsu_alt_arb.sv
// Self-checking bench for fpsu_alt_arb: directed scenarios plus a random
// run, all checked against a queue-based model of the arbiter.
module tb_fpsu_alt_arb;
  localparam int NREQ = 4, W = 68, TAGW = 9, DEPTH = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_vld;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ*W-1:0]     req_dataH, req_dataL;
  logic [NREQ*TAGW-1:0]  req_tag;
  logic                  stall;
  logic [1:0]            ALT_INP;
  logic [W-1:0]          ALTDATAH0, ALTDATAH1, ALTDATAL0, ALTDATAL1;
  logic [TAGW-1:0]       alt_tag0, alt_tag1;
  logic [2:0]            alt_src0, alt_src1;
  logic                  busy;

  int n_chk = 0;
  int n_fail = 0;

  fpsu_alt_arb #(.NREQ(NREQ), .W(W), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_dataH(req_dataH), .req_dataL(req_dataL), .req_tag(req_tag),
    .stall(stall), .ALT_INP(ALT_INP),
    .ALTDATAH0(ALTDATAH0), .ALTDATAH1(ALTDATAH1),
    .ALTDATAL0(ALTDATAL0), .ALTDATAL1(ALTDATAL1),
    .alt_tag0(alt_tag0), .alt_tag1(alt_tag1),
    .alt_src0(alt_src0), .alt_src1(alt_src1), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0]    h;
    logic [W-1:0]    l;
    logic [TAGW-1:0] t;
  } ent_t;

  ent_t       mq [NREQ][$];
  int         m_rr;
  logic [1:0] m_vld;
  ent_t       m_out [2];
  int         m_src [2];

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) mq[i].delete();
    m_rr = 0;
    m_vld = 2'b00;
    for (int s = 0; s < 2; s++) begin
      m_out[s] = '0;
      m_src[s] = 0;
    end
  endtask

  function automatic logic [NREQ-1:0] m_rdy();
    logic [NREQ-1:0] r;
    for (int i = 0; i < NREQ; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  function automatic logic m_busy();
    logic b;
    b = (m_vld != 2'b00);
    for (int i = 0; i < NREQ; i++) if (mq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // Advance one clock: model computes the edge from pre-edge state and
  // current inputs, then the DUT clocks; returns #1 after the edge.
  task automatic step();
    int              g[$];
    logic [NREQ-1:0] rdy;
    int              idx;
    rdy = m_rdy();
    if (!stall) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (mq[idx].size() > 0 && g.size() < 2) g.push_back(idx);
      end
      for (int s = 0; s < 2; s++) begin
        if (s < g.size()) begin
          m_out[s] = mq[g[s]].pop_front();
          m_src[s] = g[s];
          m_vld[s] = 1'b1;
        end else begin
          m_vld[s] = 1'b0;
        end
      end
      if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++)
      if (req_vld[i] && rdy[i])
        mq[i].push_back('{h: req_dataH[i*W +: W], l: req_dataL[i*W +: W],
                          t: req_tag[i*TAGW +: TAGW]});
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic [TAGW-1:0] t);
    logic [95:0] a, b;
    a = {$urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom()};
    req_vld[i] = 1'b1;
    req_dataH[i*W +: W] = a[W-1:0];
    req_dataL[i*W +: W] = b[W-1:0];
    req_tag[i*TAGW +: TAGW] = t;
  endtask

  task automatic clr();
    req_vld = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    clr(); set_req(0, 9'h010); set_req(1, 9'h011); step();
    clr(); set_req(0, 9'h012); step();
    n_chk++;
    if (ALT_INP !== 2'b11) begin
      n_fail++; $display("FAIL reset_setup_alt: got %b exp 11", ALT_INP);
    end
    stall = 1'b1; clr(); set_req(0, 9'h013); step();
    n_chk++;
    if (req_rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_setup_full: got %b exp 0", req_rdy[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (ALT_INP !== 2'b00 || busy !== 1'b0 || req_rdy !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_async_ctl: alt=%b busy=%b rdy=%h exp 00/0/f", ALT_INP, busy, req_rdy);
    end
    n_chk++;
    if ({ALTDATAH0, ALTDATAH1, ALTDATAL0, ALTDATAL1, alt_tag0, alt_tag1, alt_src0, alt_src1} !== '0) begin
      n_fail++; $display("FAIL reset_async_data: tag0=%h tag1=%h src0=%0d not all zero", alt_tag0, alt_tag1, alt_src0);
    end
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0; clr(); model_reset();
    set_req(2, 9'h005); step(); clr();
    n_chk++;
    if (ALT_INP !== 2'b00) begin
      n_fail++; $display("FAIL reset_no_bypass: got %b exp 00", ALT_INP);
    end
    step();
    n_chk++;
    if (ALT_INP !== 2'b01 || alt_src0 !== 3'd2 || alt_tag0 !== 9'h005) begin
      n_fail++; $display("FAIL reset_first_push: alt=%b src0=%0d tag0=%h exp 01/2/005", ALT_INP, alt_src0, alt_tag0);
    end
  endtask

  task automatic test_dual_grant();
    do_reset();
    set_req(1, 9'h001); set_req(3, 9'h003); step(); clr(); step();
    n_chk++;
    if (ALT_INP !== 2'b11 || alt_src0 !== 3'd1 || alt_src1 !== 3'd3 ||
        alt_tag0 !== 9'h001 || alt_tag1 !== 9'h003) begin
      n_fail++;
      $display("FAIL dual_grant: alt=%b src=%0d,%0d tag=%h,%h exp 11 1,3 001,003", ALT_INP, alt_src0, alt_src1, alt_tag0, alt_tag1);
    end
    // rr_ptr must have wrapped to 0: requester 0 wins slot 0 over 3.
    set_req(0, 9'h020); set_req(3, 9'h023); step(); clr(); step();
    n_chk++;
    if (ALT_INP !== 2'b11 || alt_src0 !== 3'd0 || alt_src1 !== 3'd3) begin
      n_fail++; $display("FAIL dual_rr_wrap: alt=%b src=%0d,%0d exp 11 0,3", ALT_INP, alt_src0, alt_src1);
    end
  endtask

  task automatic test_fairness();
    int gcnt [NREQ];
    int e0;
    do_reset();
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 9'(c * 16 + i));
      step();
      if (c >= 1) begin
        e0 = ((c - 1) % 2 == 0) ? 0 : 2;
        n_chk++;
        if (ALT_INP !== 2'b11 || alt_src0 !== 3'(e0) || alt_src1 !== 3'(e0 + 1)) begin
          n_fail++; $display("FAIL fair_pair c=%0d: alt=%b src=%0d,%0d exp 11 %0d,%0d", c, ALT_INP, alt_src0, alt_src1, e0, e0 + 1);
        end
        n_chk++;
        if (alt_tag0 !== m_out[0].t || alt_tag1 !== m_out[1].t) begin
          n_fail++; $display("FAIL fair_tags c=%0d: got %h,%h exp %h,%h", c, alt_tag0, alt_tag1, m_out[0].t, m_out[1].t);
        end
        gcnt[alt_src0]++; gcnt[alt_src1]++;
      end
    end
    clr();
    for (int i = 0; i < NREQ; i++) begin
      n_chk++;
      if (gcnt[i] !== 4) begin
        n_fail++; $display("FAIL fair_count req%0d: got %0d exp 4", i, gcnt[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    stall = 1'b1;
    set_req(0, 9'h0A1); step();
    set_req(0, 9'h0B2); step();
    n_chk++;
    if (req_rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL bp_rdy_low: got %b exp 0", req_rdy[0]);
    end
    set_req(0, 9'h0C3); step();
    clr(); stall = 1'b0; step();
    n_chk++;
    if (ALT_INP !== 2'b01 || alt_tag0 !== 9'h0A1) begin
      n_fail++; $display("FAIL bp_first: alt=%b tag0=%h exp 01/0a1", ALT_INP, alt_tag0);
    end
    step();
    n_chk++;
    if (ALT_INP !== 2'b01 || alt_tag0 !== 9'h0B2) begin
      n_fail++; $display("FAIL bp_second: alt=%b tag0=%h exp 01/0b2", ALT_INP, alt_tag0);
    end
    step();
    n_chk++;
    if (ALT_INP !== 2'b00 || alt_tag0 !== 9'h0B2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_drained: alt=%b tag0=%h busy=%b exp 00/0b2/0", ALT_INP, alt_tag0, busy);
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    set_req(0, 9'h01A); step(); clr(); step();
    n_chk++;
    if (ALT_INP !== 2'b01 || alt_tag0 !== 9'h01A) begin
      n_fail++; $display("FAIL hold_setup: alt=%b tag0=%h exp 01/01a", ALT_INP, alt_tag0);
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(2, 9'(9'h040 + k)); step();
      n_chk++;
      if (ALT_INP !== 2'b01 || alt_tag0 !== 9'h01A || alt_src0 !== 3'd0) begin
        n_fail++; $display("FAIL hold_k%0d: alt=%b tag0=%h src0=%0d exp 01/01a/0", k, ALT_INP, alt_tag0, alt_src0);
      end
    end
    clr(); stall = 1'b0; step();
    n_chk++;
    if (ALT_INP !== 2'b01 || alt_src0 !== 3'd2 || alt_tag0 !== 9'h040) begin
      n_fail++; $display("FAIL hold_release: alt=%b src0=%0d tag0=%h exp 01/2/040", ALT_INP, alt_src0, alt_tag0);
    end
    step();
    n_chk++;
    if (ALT_INP !== 2'b01 || alt_src0 !== 3'd2 || alt_tag0 !== 9'h041) begin
      n_fail++; $display("FAIL hold_second: alt=%b src0=%0d tag0=%h exp 01/2/041", ALT_INP, alt_src0, alt_tag0);
    end
    step();
    n_chk++;
    if (ALT_INP !== 2'b00) begin
      n_fail++; $display("FAIL hold_dropped: alt=%b exp 00", ALT_INP);
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    stall = 1'b1;
    set_req(0, 9'h051); step();
    set_req(0, 9'h052); step();
    stall = 1'b0;
    set_req(0, 9'h053);
    #1;
    n_chk++;
    if (req_rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL pp_rdy_full: got %b exp 0", req_rdy[0]);
    end
    step(); clr();
    n_chk++;
    if (ALT_INP !== 2'b01 || alt_tag0 !== 9'h051 || req_rdy[0] !== 1'b1) begin
      n_fail++; $display("FAIL pp_pop: alt=%b tag0=%h rdy0=%b exp 01/051/1", ALT_INP, alt_tag0, req_rdy[0]);
    end
    step();
    n_chk++;
    if (ALT_INP !== 2'b01 || alt_tag0 !== 9'h052) begin
      n_fail++; $display("FAIL pp_second: alt=%b tag0=%h exp 01/052", ALT_INP, alt_tag0);
    end
    step();
    n_chk++;
    if (ALT_INP !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pp_empty: alt=%b busy=%b exp 00/0", ALT_INP, busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(1, 0) == 1) set_req(i, 9'($urandom()));
        else req_vld[i] = 1'b0;
      end
      stall = ($urandom_range(3, 0) == 0);
      #1;
      n_chk++;
      if (req_rdy !== m_rdy() || busy !== m_busy()) begin
        n_fail++; $display("FAIL rnd_comb c=%0d: rdy=%h busy=%b exp %h/%b", c, req_rdy, busy, m_rdy(), m_busy());
      end
      step();
      n_chk++;
      if (ALT_INP !== m_vld) begin
        n_fail++; $display("FAIL rnd_vld c=%0d: got %b exp %b", c, ALT_INP, m_vld);
      end
      n_chk++;
      if (ALTDATAH0 !== m_out[0].h || ALTDATAL0 !== m_out[0].l ||
          alt_tag0 !== m_out[0].t || alt_src0 !== 3'(m_src[0])) begin
        n_fail++; $display("FAIL rnd_slot0 c=%0d: tag=%h src=%0d h=%h exp tag=%h src=%0d h=%h", c, alt_tag0, alt_src0, ALTDATAH0, m_out[0].t, m_src[0], m_out[0].h);
      end
      n_chk++;
      if (ALTDATAH1 !== m_out[1].h || ALTDATAL1 !== m_out[1].l ||
          alt_tag1 !== m_out[1].t || alt_src1 !== 3'(m_src[1])) begin
        n_fail++; $display("FAIL rnd_slot1 c=%0d: tag=%h src=%0d h=%h exp tag=%h src=%0d h=%h", c, alt_tag1, alt_src1, ALTDATAH1, m_out[1].t, m_src[1], m_out[1].h);
      end
    end
    clr(); stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    req_vld = '0;
    req_dataH = '0;
    req_dataL = '0;
    req_tag = '0;
    model_reset();
    test_reset();
    test_dual_grant();
    test_fairness();
    test_backpressure();
    test_stall_hold();
    test_full_pushpop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
